// File: rtl/dac_ltc2624_ctrl.sv
// rtl/dac_ltc2624_ctrl.sv - LTC2624 write scheduler and SPI frame sequencer
module dac_ltc2624_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4,
    parameter int CLR_CYC = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_EN,
    input  logic [1:0]  WR_CH,
    input  logic [11:0] WR_DATA,
    input  logic        CLR_REQ,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  PENDING,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SETUP, S_SHIFT, S_HOLD, S_GAP
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [4:0]       bit_idx, bit_idx_n;
    logic [31:0]      shreg, shreg_n;
    logic [11:0]      data_q [4];
    logic [11:0]      data_n [4];
    logic [3:0]       pend_q, pend_n;
    logic [1:0]       ptr, ptr_n;
    logic             clr_flag, clr_flag_n;
    logic             sck, sck_n, mosi, mosi_n, cs, cs_n, clr_n, clr_n_n, done, done_n;
    logic             found;
    logic [1:0]       gch, idx;
    logic [3:0]       pend_kill;
    logic [31:0]      frame;

    // Register all state and pin drivers; reset parks the bus safely
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
            pend_q   <= '0;
            ptr      <= '0;
            clr_flag <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs       <= 1'b1;
            clr_n    <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            data_q   <= data_n;
            pend_q   <= pend_n;
            ptr      <= ptr_n;
            clr_flag <= clr_flag_n;
            sck      <= sck_n;
            mosi     <= mosi_n;
            cs       <= cs_n;
            clr_n    <= clr_n_n;
            done     <= done_n;
        end
    end

    // Round-robin grant, frame sequencing and pending/clear bookkeeping
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        data_n     = data_q;
        ptr_n      = ptr;
        clr_flag_n = clr_flag;
        sck_n      = sck;
        mosi_n     = mosi;
        cs_n       = cs;
        clr_n_n    = clr_n;
        done_n     = 1'b0;
        pend_kill  = '0;
        found      = 1'b0;
        gch        = ptr;
        idx        = '0;
        frame      = '0;

        // Scan downward so the nearest pending channel from ptr wins
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (pend_q[idx]) begin
                found = 1'b1;
                gch   = idx;
            end
        end

        case (state)
            S_IDLE: begin
                if (clr_flag || CLR_REQ) begin
                    state_n    = S_CLEAR;
                    cnt_n      = '0;
                    clr_n_n    = 1'b0;
                    clr_flag_n = 1'b0;
                    pend_kill  = 4'hF;
                end else if (found) begin
                    frame        = {8'h00, 4'b0011, 2'b00, gch, data_q[gch], 4'h0};
                    mosi_n       = frame[31];
                    shreg_n      = {frame[30:0], 1'b0};
                    pend_kill[gch] = 1'b1;
                    ptr_n        = gch + 2'd1;
                    cs_n         = 1'b0;
                    sck_n        = 1'b0;
                    cnt_n        = '0;
                    bit_idx_n    = '0;
                    state_n      = S_SETUP;
                end
            end
            S_CLEAR: begin
                if (cnt == CLR_LAST) begin
                    clr_n_n = 1'b1;
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_SETUP: begin
                if (cnt == DIV_LAST) begin
                    cnt_n   = '0;
                    state_n = S_SHIFT;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_SHIFT: begin
                if (cnt == BIT_LAST) begin
                    sck_n = 1'b0;
                    cnt_n = '0;
                    if (bit_idx == 5'd31) begin
                        state_n = S_HOLD;
                    end else begin
                        bit_idx_n = bit_idx + 5'd1;
                        mosi_n    = shreg[31];
                        shreg_n   = {shreg[30:0], 1'b0};
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                    if (cnt == DIV_LAST) sck_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == DIV_LAST) begin
                    cs_n    = 1'b1;
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cs_n    = 1'b1;
                sck_n   = 1'b0;
                clr_n_n = 1'b1;
            end
        endcase

        // A clear requested outside IDLE waits until the sequencer is idle again
        if (CLR_REQ && state != S_IDLE) clr_flag_n = 1'b1;

        // Writes land after grant/clear so a same-cycle write re-arms the channel
        pend_n = pend_q & ~pend_kill;
        if (WR_EN) begin
            pend_n[WR_CH] = 1'b1;
            data_n[WR_CH] = WR_DATA;
        end
    end

    assign BUSY     = (state != S_IDLE);
    assign DONE     = done;
    assign PENDING  = pend_q;
    assign SPI_SCK  = sck;
    assign SPI_MOSI = mosi;
    assign DAC_CS   = cs;
    assign DAC_CLR  = clr_n;

endmodule

// File: tb/tb_dac_ltc2624_ctrl.sv
// tb/tb_dac_ltc2624_ctrl.sv - scoreboard bench for dac_ltc2624_ctrl
module tb_dac_ltc2624_ctrl;

    localparam int CLK_DIV = 2;
    localparam int GAP_CYC = 4;
    localparam int CLR_CYC = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WR_EN = 1'b0;
    logic [1:0]  WR_CH = '0;
    logic [11:0] WR_DATA = '0;
    logic        CLR_REQ = 1'b0;
    logic        BUSY, DONE, SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR;
    logic [3:0]  PENDING;

    dac_ltc2624_ctrl #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .CLR_CYC(CLR_CYC)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_CH(WR_CH), .WR_DATA(WR_DATA),
        .CLR_REQ(CLR_REQ), .BUSY(BUSY), .DONE(DONE), .PENDING(PENDING),
        .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI), .DAC_CS(DAC_CS), .DAC_CLR(DAC_CLR)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: pending set, latest values, rotating pointer, owed clear
    logic [3:0]  m_pend = '0;
    logic [11:0] m_val [4];
    int          m_ptr = 0;
    bit          m_owed = 0;
    logic [31:0] exp_q [$];
    int          n_frames = 0, n_clears = 0;
    logic        m_cs_p = 1'b1, m_clr_p = 1'b1;
    int          gc;
    bit          gfound;

    always @(posedge CLK) begin
        #1;
        if (RST) begin
            m_pend = '0; m_ptr = 0; m_owed = 0; exp_q.delete();
            m_cs_p = 1'b1; m_clr_p = 1'b1;
        end else begin
            if (CLR_REQ) m_owed = 1;
            if (m_clr_p && !DAC_CLR) begin
                chk("clr_owed", {31'd0, m_owed}, 32'd1);
                m_owed = 0;
                m_pend = '0;
                n_clears++;
            end
            if (m_cs_p && !DAC_CS) begin
                chk("clr_prio", {31'd0, m_owed}, 32'd0);
                gfound = 0;
                for (int k = 0; k < 4; k++) begin
                    gc = (m_ptr + k) % 4;
                    if (!gfound && m_pend[gc]) gfound = 1;
                    else gc = gc;
                    if (gfound && k == 0) break;
                    if (gfound) break;
                end
                chk("grant_has_pending", {31'd0, gfound}, 32'd1);
                if (gfound) begin
                    exp_q.push_back({8'h00, 4'h3, 4'(gc), m_val[gc], 4'h0});
                    m_pend[gc] = 1'b0;
                    m_ptr = (gc + 1) % 4;
                end
                n_frames++;
            end
            if (WR_EN) begin
                m_pend[WR_CH] = 1'b1;
                m_val[WR_CH] = WR_DATA;
            end
            m_cs_p = DAC_CS;
            m_clr_p = DAC_CLR;
        end
    end

    // Monitor: decode the SPI pins into frames and check timing against the queue
    logic        c_cs_p = 1'b1, c_sck_p = 1'b0, c_mosi_p = 1'b0, c_clr_p = 1'b1;
    bit          in_frame = 0, in_clr = 0, have_prev = 0;
    int          low_cnt = 0, high_cnt = 0, rises = 0, glitch = 0, clr_cnt = 0, sck_in_clr = 0;
    int          n_done = 0, spurious_done = 0, stray = 0;
    logic [31:0] word = '0, last_word = '0, expw;

    always @(posedge CLK) begin
        #2;
        if (RST) begin
            c_cs_p = 1'b1; c_sck_p = 1'b0; c_mosi_p = 1'b0; c_clr_p = 1'b1;
            in_frame = 0; in_clr = 0;
        end else begin
            if (DONE) begin
                n_done++;
                if (!(!c_cs_p && DAC_CS)) spurious_done++;
            end
            if (c_cs_p && !DAC_CS) begin
                if (have_prev) chk("cs_gap", {31'd0, high_cnt >= GAP_CYC}, 32'd1);
                in_frame = 1; low_cnt = 0; rises = 0; word = '0; glitch = 0;
            end
            if (!c_sck_p && SPI_SCK) begin
                if (in_frame) begin
                    word = {word[30:0], SPI_MOSI};
                    rises++;
                end else stray++;
            end
            if (SPI_MOSI !== c_mosi_p) begin
                if (!(!SPI_SCK && (c_sck_p || (c_cs_p && !DAC_CS)))) begin
                    if (in_frame) glitch++;
                    else stray++;
                end
            end
            if (!c_cs_p && DAC_CS && in_frame) begin
                chk("cs_low_cycles", low_cnt, 66 * CLK_DIV);
                chk("sck_rises", rises, 32);
                chk("mosi_stable", glitch, 0);
                chk("done_at_cs_rise", {31'd0, DONE}, 32'd1);
                chk("pending_flags", {28'd0, PENDING}, {28'd0, m_pend});
                if (exp_q.size() == 0) begin
                    chk("frame_expected", 32'd0, 32'd1);
                end else begin
                    expw = exp_q.pop_front();
                    chk("frame_word", word, expw);
                end
                last_word = word;
                in_frame = 0; have_prev = 1; high_cnt = 0;
            end
            if (!DAC_CS) low_cnt++;
            else high_cnt++;
            if (c_clr_p && !DAC_CLR) begin
                chk("clr_outside_frame", {30'd0, DAC_CS, in_frame}, 32'd2);
                in_clr = 1; clr_cnt = 0; sck_in_clr = 0;
            end
            if (!DAC_CLR) clr_cnt++;
            if (in_clr && SPI_SCK) sck_in_clr++;
            if (!c_clr_p && DAC_CLR && in_clr) begin
                chk("clr_len", clr_cnt, CLR_CYC);
                chk("clr_sck_idle", sck_in_clr, 0);
                in_clr = 0;
            end
            c_cs_p = DAC_CS; c_sck_p = SPI_SCK; c_mosi_p = SPI_MOSI; c_clr_p = DAC_CLR;
        end
    end

    task automatic wr(input int ch, input int d);
        WR_EN = 1'b1; WR_CH = 2'(ch); WR_DATA = 12'(d);
        @(negedge CLK);
        WR_EN = 1'b0;
    endtask

    task automatic clr_pulse();
        CLR_REQ = 1'b1;
        @(negedge CLK);
        CLR_REQ = 1'b0;
    endtask

    task automatic wait_idle();
        int idle = 0;
        for (int i = 0; i < 20000 && idle < 3; i++) begin
            @(negedge CLK);
            if (!BUSY && PENDING == 4'd0) idle++;
            else idle = 0;
        end
        chk("settle", idle, 3);
    endtask

    task automatic wait_bits(input int n);
        int t = 0;
        while (!(in_frame && rises >= n) && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        chk("reach_bit", {31'd0, in_frame && rises >= n}, 32'd1);
    endtask

    int f0, c0, d0;

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_cs", {31'd0, DAC_CS}, 32'd1);
        chk("rst_clr", {31'd0, DAC_CLR}, 32'd1);
        chk("rst_sck", {31'd0, SPI_SCK}, 32'd0);
        chk("rst_mosi", {31'd0, SPI_MOSI}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_pending", {28'd0, PENDING}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // single write
        f0 = n_frames; d0 = n_done;
        wr(2, 'hABC);
        wait_idle();
        chk("single_word", last_word, 32'h0032ABC0);
        chk("single_frames", n_frames - f0, 1);
        chk("single_done", n_done - d0, 1);

        // burst of four, then wrap ordering
        f0 = n_frames;
        wr(0, 'h111); wr(1, 'h222); wr(2, 'h333); wr(3, 'h444);
        wait_idle();
        chk("burst_frames", n_frames - f0, 4);
        chk("burst_last", last_word, 32'h00334440);
        wr(3, 'h3C3);
        wait_bits(3);
        wr(1, 'h555); wr(0, 'h0AA);
        wait_idle();
        chk("wrap_last_is_ch1", last_word, 32'h00315550);

        // overwrite before grant
        f0 = n_frames;
        wr(0, 'h123);
        wait_bits(2);
        wr(3, 'h100); wr(3, 'h200);
        wait_idle();
        chk("overwrite_word", last_word, 32'h00332000);
        chk("overwrite_frames", n_frames - f0, 2);

        // rewrite of the channel being shifted
        f0 = n_frames;
        wr(0, 'h0AA);
        wait_bits(4);
        wr(0, 'h0BB);
        wait_idle();
        chk("rewrite_word", last_word, 32'h00300BB0);
        chk("rewrite_frames", n_frames - f0, 2);

        // clear mid-frame
        f0 = n_frames; c0 = n_clears;
        wr(0, 'h0F0);
        wait_bits(6);
        wr(1, 'h321);
        clr_pulse();
        wait_idle();
        chk("clear_frames", n_frames - f0, 1);
        chk("clear_count", n_clears - c0, 1);
        chk("clear_pending", {28'd0, PENDING}, 32'd0);

        // reset mid-shift
        d0 = n_done;
        wr(0, 'h777);
        wait_bits(10);
        RST = 1'b1;
        #1;
        chk("mid_rst_cs", {31'd0, DAC_CS}, 32'd1);
        chk("mid_rst_sck", {31'd0, SPI_SCK}, 32'd0);
        chk("mid_rst_mosi", {31'd0, SPI_MOSI}, 32'd0);
        chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        chk("mid_rst_no_done", n_done - d0, 0);
        f0 = n_frames;
        wr(2, 'h5A5);
        wait_idle();
        chk("post_rst_word", last_word, 32'h00325A50);
        chk("post_rst_frames", n_frames - f0, 1);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) clr_pulse();
            else wr($urandom_range(0, 3), $urandom_range(0, 4095));
            repeat ($urandom_range(0, 120)) @(negedge CLK);
        end
        wait_idle();

        chk("queue_drained", exp_q.size(), 0);
        chk("no_owed_clear", {31'd0, m_owed}, 32'd0);
        chk("no_spurious_done", spurious_done, 0);
        chk("no_stray_bus", stray, 0);
        chk("final_pending", {28'd0, PENDING}, {28'd0, m_pend});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
